bmp_stream_src: RTL and testbench
=================================

# bmp_stream_src

Synthesizable AXI-stream image source: on a start pulse it reads one frame of pixel bytes from a byte-wide synchronous frame memory and streams them out on an AXI-stream master port. It skips the file header region and marks the last byte with tlast. It is the transmit end of the 8-bit image stream consumed by the processing `dut`'s `s_axis_*` slave port, and it replaces the simulation-only file reader when the pipeline runs on hardware.

## Interface
- `IMG_BYTES`, default 1786050 (945*630*3): pixel bytes per frame; must be ≥ 1.
- `HDR_BYTES`, default 768: header bytes at the start of memory; these are never streamed.
- `ADDR_W`, default 22: memory address width; must satisfy 2^ADDR_W ≥ HDR_BYTES+IMG_BYTES.
- Reset (already decided): one clock; reset is asynchronous and active-high.
- `clk` in 1: single clock; everything samples on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to send one frame; ignored unless the state is IDLE.
- `busy` out 1: high from the cycle after an accepted start until the cycle done is asserted.
- `done` out 1: one-cycle pulse after the last byte handshakes.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory read address.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_rd_en`.
- `m_axis_tvalid` out 1: output byte valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out 8: pixel byte.
- `m_axis_tlast` out 1: high with byte IMG_BYTES-1 only.

## Operation
- States:
  - IDLE: on `start` load rd_ptr=HDR_BYTES, issue_cnt=0, sent_cnt=0, then go to RUN.
  - RUN: when the last byte handshakes (tvalid&tready and sent_cnt==IMG_BYTES-1), go to DONE.
  - DONE: lasts 1 cycle with `done`=1, `busy`=0, then go to IDLE.
- Read issue (combinational in RUN): `mem_rd_en` = (issue_cnt < IMG_BYTES) && (fifo_count + inflight − pop < 2).
  - pop = m_axis_tvalid & m_axis_tready.
  - inflight = registered copy of the previous cycle's `mem_rd_en`.
  - `mem_addr` = rd_ptr. Each issue increments rd_ptr and issue_cnt.
- Output buffer: 2-entry FIFO.
  - Writes `mem_rdata` when inflight=1 and pops on a handshake; a simultaneous push and pop is legal.
  - Overflow is impossible by the credit rule; any overflow is a design error.
- Outputs:
  - `m_axis_tdata` is the FIFO head; `m_axis_tvalid` = FIFO non-empty.
  - `m_axis_tlast` = tvalid && sent_cnt==IMG_BYTES-1.
  - sent_cnt increments per handshake.
- AXI rule: once tvalid is high, tvalid and tdata stay stable until the handshake, regardless of tready.
- `start` while busy or in DONE is dropped; no queuing.
- Reset, async at any time including mid-frame:
  - State=IDLE; FIFO and inflight cleared; all counters 0.
  - All outputs 0: busy, done, mem_rd_en, mem_addr, tvalid, tdata, tlast.
  - The partial frame is abandoned without tlast.
- Counters are ADDR_W bits wide. No wrap occurs within a legal frame; rd_ptr ends at HDR_BYTES+IMG_BYTES.

## Timing
- Start handshake:
  - `start` sampled at edge E0 gives `busy`=1 and `mem_rd_en`=1 with `mem_addr`=HDR_BYTES after E0.
  - Data returns after E1; the FIFO captures it at E2.
  - First `m_axis_tvalid` appears after E2, i.e. 3 cycles after start is sampled.
- Throughput: with tready held at 1, one byte per cycle with no bubbles. The last handshake is at edge E2+IMG_BYTES.
- `done` is high in the single cycle after the last handshake edge; `busy` drops in that same cycle.
- Backpressure:
  - tready=0 stops reads after at most 2 bytes are buffered/in flight.
  - When tready rises, the first handshake happens the same cycle and the stream resumes at 1 byte/cycle without gaps.
- Back-to-back frames: earliest accepted next start is in the cycle after DONE (IDLE). Minimum frame-to-frame overhead is 4 cycles.

## Test plan
- Parameters HDR_BYTES=4, IMG_BYTES=16, memory[i]=i. Pulse start, tready=1 -> bytes 4..19 on 16 consecutive cycles, first tvalid 3 cycles after start, tlast only on 19, done one cycle after the final handshake, 16 reads total.
- Same setup, tready pattern 1,0,0,1,0,1 repeating -> identical byte sequence, no duplicates or drops. tdata is stable while tvalid&!tready. A checker confirms FIFO occupancy plus in-flight reads never exceeds 2.
- tready=0 for 20 cycles after start -> exactly 2 reads issued, tvalid held at 1 with tdata=4. After release, the remaining 15 bytes stream gap-free.
- Start pulsed again mid-frame and during the DONE cycle -> ignored, exactly 16 bytes emitted, a single done pulse.
- Assert rst after 7 handshakes -> all outputs 0 within the reset cycle, no tlast emitted. A new start then restarts cleanly from byte 4.
- Default parameters, tready=1 -> 1786050 bytes, tlast on the last one, final mem_addr=1786817, done exactly once.

Source files
------------

// File: rtl/bmp_stream_src_if.sv
// 8-bit AXI-stream link carrying image bytes from the frame source
// to the processing pipeline.
interface bmp_stream_src_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/bmp_stream_src.sv
// Frame memory to AXI-stream image source: skips the header bytes and
// streams one frame per start pulse through a 2-entry credit FIFO.
module bmp_stream_src #(
    parameter int IMG_BYTES = 1786050,
    parameter int HDR_BYTES = 768,
    parameter int ADDR_W    = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    bmp_stream_src_if.master  m_axis
);

    localparam logic [ADDR_W-1:0] L_IMG  = ADDR_W'(IMG_BYTES);
    localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(IMG_BYTES - 1);
    localparam logic [ADDR_W-1:0] L_HDR  = ADDR_W'(HDR_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_issue_cnt;
    logic [ADDR_W-1:0] r_sent_cnt;
    logic              r_inflight;
    logic [7:0]        r_fifo [2];
    logic              r_wr_sel;
    logic              r_rd_sel;
    logic [1:0]        r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_last;
    logic [2:0]        w_used;
    logic [2:0]        w_limit;
    logic              w_rd_en;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & m_axis.tready;
    assign w_push  = r_inflight;
    assign w_last  = (r_sent_cnt == L_LAST);

    // Credit rule: buffered + in-flight bytes never exceed two.
    assign w_used  = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_rd_en = (r_state == S_RUN)
                   && (r_issue_cnt < L_IMG)
                   && (w_used < w_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_issue_cnt <= '0;
            r_sent_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_push) begin
                r_fifo[r_wr_sel] <= mem_rdata;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_rd_sel   <= ~r_rd_sel;
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rd_ptr    <= L_HDR;
                        r_issue_cnt <= '0;
                        r_sent_cnt  <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pop && w_last)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign mem_rd_en     = w_rd_en;
    assign mem_addr      = r_rd_ptr;
    assign m_axis.tvalid = w_valid;
    assign m_axis.tdata  = r_fifo[r_rd_sel];
    assign m_axis.tlast  = w_valid & w_last;

endmodule

// File: tb/tb_bmp_stream_src.sv
// Bench for bmp_stream_src: vector table of ready patterns, random
// backpressure frames and a mid-frame reset, checked by a stream model.
module tb_bmp_stream_src;

    localparam int HDR = 4;
    localparam int IMG = 16;
    localparam int AW  = 6;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0;

    bmp_stream_src_if axis ();

    bmp_stream_src #(
        .IMG_BYTES (IMG),
        .HDR_BYTES (HDR),
        .ADDR_W    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .m_axis    (axis)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory holds memory[i] = i with one cycle read latency.
    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= 8'(mem_addr);

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    int   n_hs, n_reads, n_done, n_tlast, n_bubble;
    int   first_v, done_c, last_addr;
    bit   mon_en = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic clr();
        n_hs      = 0;
        n_reads   = 0;
        n_done    = 0;
        n_tlast   = 0;
        n_bubble  = 0;
        first_v   = -1;
        done_c    = -1;
        last_addr = -1;
    endtask

    // Stream model: byte k of a frame must be memory[HDR+k].
    always @(negedge clk) begin
        logic hs;
        if (rst) begin
            prev_stall = 1'b0;
        end else if (mon_en) begin
            hs = axis.tvalid && axis.tready;
            if (prev_stall) begin
                chk("hold_valid", int'(axis.tvalid), 1);
                chk("hold_data", int'(axis.tdata), int'(prev_data));
            end
            if (axis.tvalid)
                chk("tlast", int'(axis.tlast), int'(n_hs == IMG - 1));
            else
                chk("tlast_idle", int'(axis.tlast), 0);
            if (axis.tvalid && first_v < 0) first_v = cyc;
            if (hs) begin
                chk("tdata", int'(axis.tdata), (HDR + n_hs) % 256);
                if (axis.tlast) n_tlast++;
                n_hs++;
            end
            if (!hs && axis.tready && n_hs > 0 && n_hs < IMG)
                n_bubble++;
            if (mem_rd_en) begin
                chk("rd_addr", int'(mem_addr), HDR + n_reads);
                last_addr = int'(mem_addr);
                n_reads++;
            end
            chk("occupancy", int'((n_reads - n_hs) <= 2), 1);
            if (done) begin
                n_done++;
                done_c = cyc;
                chk("busy_in_done", int'(busy), 0);
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
        end
    end

    // Ready driver: 0 always, 1 pattern 1,0,0,1,0,1, 2 random, 3 stall.
    int rmode = 0;
    int rel_c = 0;
    int pidx  = 0;

    always @(posedge clk) begin
        #2;
        case (rmode)
            0: axis.tready = 1'b1;
            1: begin
                axis.tready = (pidx % 6 == 0) || (pidx % 6 == 3)
                           || (pidx % 6 == 5);
                pidx++;
            end
            2: axis.tready = 1'($urandom_range(0, 1));
            3: axis.tready = (cyc >= rel_c);
            default: axis.tready = 1'b0;
        endcase
    end

    typedef struct {
        int rmode;
        bit restart;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(vec_t v);
        int s;
        clr();
        @(posedge clk);
        #1;
        s     = cyc;
        rmode = v.rmode;
        rel_c = s + 21;
        pidx  = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = v.restart && (busy || done);
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        chk("rd_en_after_start", int'(mem_rd_en), 1);
        chk("addr_after_start", int'(mem_addr), HDR);
        for (int k = 0; k < 400 && n_done == 0; k++) begin
            @(posedge clk);
            #1;
            start = v.restart && (busy || done);
            if (v.rmode == 3 && cyc == s + 20) begin
                chk("stall_reads", n_reads, 2);
                chk("stall_valid", int'(axis.tvalid), 1);
                chk("stall_data", int'(axis.tdata), HDR);
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            start = v.restart && (busy || done);
        end
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("bytes", n_hs, IMG);
        chk("reads", n_reads, IMG);
        chk("done_pulses", n_done, 1);
        chk("tlast_count", n_tlast, 1);
        chk("last_addr", last_addr, HDR + IMG - 1);
        chk("first_valid", first_v - s, v.exp_first);
        if (v.exp_done >= 0) begin
            chk("done_latency", done_c - s, v.exp_done);
            chk("bubbles", n_bubble, 0);
        end
    endtask

    initial begin
        vec_t rv;
        int   s;

        vecs[0] = '{rmode: 0, restart: 1'b0, exp_first: 3, exp_done: 19};
        vecs[1] = '{rmode: 1, restart: 1'b0, exp_first: 3, exp_done: -1};
        vecs[2] = '{rmode: 3, restart: 1'b0, exp_first: 3, exp_done: 37};
        vecs[3] = '{rmode: 0, restart: 1'b1, exp_first: 3, exp_done: 19};
        vecs[4] = '{rmode: 2, restart: 1'b0, exp_first: 3, exp_done: -1};
        vecs[5] = '{rmode: 1, restart: 1'b1, exp_first: 3, exp_done: -1};

        #1 rst = 1'b1;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(mem_rd_en), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_tvalid", int'(axis.tvalid), 0);
        chk("rst_tdata", int'(axis.tdata), 0);
        chk("rst_tlast", int'(axis.tlast), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        for (int r = 0; r < 4; r++) begin
            rv = '{rmode: 2, restart: 1'($urandom_range(0, 1)),
                   exp_first: 3, exp_done: -1};
            run_vec(rv);
        end

        // Reset in the middle of a frame, then a clean frame.
        clr();
        @(posedge clk);
        #1;
        s     = cyc;
        rmode = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 100 && n_hs < 7; k++) @(negedge clk);
        chk("reached_7", int'(n_hs >= 7), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_rd_en", int'(mem_rd_en), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        chk("mid_rst_tvalid", int'(axis.tvalid), 0);
        chk("mid_rst_tdata", int'(axis.tdata), 0);
        chk("mid_rst_tlast", int'(axis.tlast), 0);
        chk("no_tlast_partial", n_tlast, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
